// File: rtl/nvram_responder.sv
// NVRAM device model on the active-low /CE /WE /OE strobe bus: commits writes on the
// trailing strobe edge, returns read data after a fixed access latency, flags violations.
module nvram_responder #(
  parameter int AddrWidth    = 8,
  parameter int DataWidth    = 8,
  parameter int AccessCycles = 3
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 CE,
  input  logic                 WE,
  input  logic                 OE,
  input  logic [AddrWidth-1:0] Addr,
  input  logic [DataWidth-1:0] DataIn,
  output logic [DataWidth-1:0] DataOut,
  output logic                 DataValid,
  output logic                 WriteStrobe,
  output logic                 Error,
  output logic [1:0]           State
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SELECT = 2'b01,
    READ   = 2'b10,
    WRITE  = 2'b11
  } state_t;

  localparam logic [3:0] ACC = 4'(AccessCycles);

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [AddrWidth-1:0] lat_addr_q, lat_addr_d;
  logic [AddrWidth-1:0] hold_addr_q, hold_addr_d;
  logic [DataWidth-1:0] hold_data_q, hold_data_d;
  logic [DataWidth-1:0] dout_d;
  logic                 dv_d, ws_d, err_d;
  logic                 commit;
  logic                 rd_req, wr_req, viol;

  logic [DataWidth-1:0] mem [2**AddrWidth];

  assign rd_req = !CE && !OE && WE;
  assign wr_req = !CE && !WE && OE;
  assign viol   = !CE && !WE && !OE;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_addr_d  = lat_addr_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    dout_d      = DataOut;
    dv_d        = DataValid;
    ws_d        = 1'b0;
    err_d       = Error;
    commit      = 1'b0;
    if (viol) begin
      // Bus contention: abandon whatever was in flight, never drive or commit.
      err_d   = 1'b1;
      dv_d    = 1'b0;
      state_d = SELECT;
    end else begin
      case (state_q)
        IDLE, SELECT: begin
          dv_d = 1'b0;
          if (rd_req) begin
            state_d    = READ;
            lat_addr_d = Addr;
            cnt_d      = ACC;
          end else if (wr_req) begin
            state_d     = WRITE;
            hold_addr_d = Addr;
            hold_data_d = DataIn;
          end else if (!CE) begin
            state_d = SELECT;
          end else begin
            state_d = IDLE;
          end
        end
        READ: begin
          if (CE || OE) begin
            dv_d    = 1'b0;
            cnt_d   = 4'd0;
            state_d = CE ? IDLE : SELECT;
          end else if (Addr != lat_addr_q) begin
            // Address moved under an open read: restart the access time.
            lat_addr_d = Addr;
            cnt_d      = ACC;
            dv_d       = 1'b0;
          end else if (cnt_q > 4'd1) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            cnt_d  = 4'd0;
            dv_d   = 1'b1;
            dout_d = mem[lat_addr_q];
          end
        end
        WRITE: begin
          if (CE || WE) begin
            commit  = 1'b1;
            ws_d    = 1'b1;
            state_d = CE ? IDLE : SELECT;
          end else begin
            hold_addr_d = Addr;
            hold_data_d = DataIn;
            if (Addr != hold_addr_q) err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      lat_addr_q  <= '0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      DataOut     <= '0;
      DataValid   <= 1'b0;
      WriteStrobe <= 1'b0;
      Error       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_addr_q  <= lat_addr_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      DataOut     <= dout_d;
      DataValid   <= dv_d;
      WriteStrobe <= ws_d;
      Error       <= err_d;
    end
  end

  // The array survives Reset; commit is already dead while Reset holds state at IDLE.
  always_ff @(posedge Clk) begin
    if (commit && !Reset) mem[hold_addr_q] <= hold_data_q;
  end

  assign State = state_q;

endmodule

// File: tb/tb_nvram_responder.sv
// Directed bench for nvram_responder: driver tasks push expected responses, a monitor
// pops and compares them against WriteStrobe pulses and DataValid rising edges.
module tb_nvram_responder;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int ACC = 3;
  localparam int W   = 1 + DW + 32;

  logic          clk;
  logic          rst;
  logic          ce, we, oe;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          write_strobe;
  logic          error;
  logic [1:0]    state;

  logic [W-1:0] exp_q[$];
  int           compared   = 0;
  int           mismatched = 0;
  int           cyc        = 0;
  logic         prev_dv    = 1'b0;

  nvram_responder #(
    .AddrWidth(AW),
    .DataWidth(DW),
    .AccessCycles(ACC)
  ) dut (
    .Clk(clk),
    .Reset(rst),
    .CE(ce),
    .WE(we),
    .OE(oe),
    .Addr(addr),
    .DataIn(data_in),
    .DataOut(data_out),
    .DataValid(data_valid),
    .WriteStrobe(write_strobe),
    .Error(error),
    .State(state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: kind 1 = write commit, kind 0 = read data presented
  task automatic got_event(input logic kind, input logic [DW-1:0] data);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL unexpected_event: got kind %0d data %0h at cycle %0d, expected none",
               kind, data, cyc);
    end else begin
      e = exp_q.pop_front();
      check("resp_kind", 32'(kind), 32'(e[W-1]));
      check("resp_cycle", 32'(cyc), e[31:0]);
      if (!kind) check("read_data", 32'(data), 32'(e[W-2:32]));
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (write_strobe === 1'b1) got_event(1'b1, '0);
    if (data_valid === 1'b1 && !prev_dv) got_event(1'b0, data_out);
    prev_dv = (data_valid === 1'b1);
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ce = 1'b1; we = 1'b1; oe = 1'b1;
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int hold, input bit ce_trail);
    @(negedge clk);
    ce = 1'b0; we = 1'b0; oe = 1'b1; addr = a; data_in = d;
    repeat (hold) @(negedge clk);
    exp_q.push_back({1'b1, DW'(0), 32'(cyc + 1)});
    if (ce_trail) ce = 1'b1;
    else          we = 1'b1;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
    @(negedge clk);
    ce = 1'b0; we = 1'b1; oe = 1'b0; addr = a;
    exp_q.push_back({1'b0, d, 32'(cyc + 1 + ACC)});
    repeat (hold) @(negedge clk);
    oe = 1'b1; ce = 1'b1;
    @(negedge clk);
    check("dv_fall", 32'(data_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; we = 1'b1; oe = 1'b1; addr = '0; data_in = '0;
    repeat (2) @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_dv", 32'(data_valid), 32'd0);
    check("rst_ws", 32'(write_strobe), 32'd0);
    check("rst_err", 32'(error), 32'd0);
    check("rst_dout", 32'(data_out), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("quiet_state", 32'(state), 32'd0);
      check("quiet_dv", 32'(data_valid), 32'd0);
    end

    // single-cycle write preload, then A5 with WE low 3 cycles, read back via SELECT
    do_write(8'h13, 8'h5A, 1, 1'b0);
    idle(1);
    do_write(8'h12, 8'hA5, 3, 1'b0);
    @(negedge clk);
    check("select_after_write", 32'(state), 32'd1);
    ce = 1'b0; we = 1'b1; oe = 1'b0; addr = 8'h12;
    exp_q.push_back({1'b0, 8'hA5, 32'(cyc + 1 + ACC)});
    repeat (6) @(negedge clk);
    oe = 1'b1; ce = 1'b1;
    @(negedge clk);
    check("dv_fall", 32'(data_valid), 32'd0);

    // trailing CE commit
    do_write(8'hFF, 8'h3C, 2, 1'b1);
    idle(1);
    do_read(8'hFF, 8'h3C, 6);

    // address change during an open read
    @(negedge clk);
    ce = 1'b0; we = 1'b1; oe = 1'b0; addr = 8'h12;
    exp_q.push_back({1'b0, 8'hA5, 32'(cyc + 1 + ACC)});
    repeat (5) @(negedge clk);
    addr = 8'h13;
    exp_q.push_back({1'b0, 8'h5A, 32'(cyc + 1 + ACC)});
    @(negedge clk);
    check("dv_drop_on_addr", 32'(data_valid), 32'd0);
    repeat (4) @(negedge clk);
    oe = 1'b1; ce = 1'b1;
    @(negedge clk);
    check("dv_fall", 32'(data_valid), 32'd0);

    // protocol violation
    check("err_before_viol", 32'(error), 32'd0);
    @(negedge clk);
    ce = 1'b0; we = 1'b0; oe = 1'b0; addr = 8'h40; data_in = 8'hEE;
    @(negedge clk);
    check("viol_err", 32'(error), 32'd1);
    check("viol_state", 32'(state), 32'd1);
    ce = 1'b1; we = 1'b1; oe = 1'b1;
    idle(2);
    do_write(8'h20, 8'h11, 2, 1'b0);
    idle(1);
    do_read(8'h20, 8'h11, 6);
    check("err_sticky", 32'(error), 32'd1);

    // reset in the middle of a write discards it
    @(negedge clk);
    ce = 1'b0; we = 1'b0; oe = 1'b1; addr = 8'h20; data_in = 8'h77;
    repeat (2) @(negedge clk);
    check("in_write", 32'(state), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_err", 32'(error), 32'd0);
    check("async_rst_ws", 32'(write_strobe), 32'd0);
    @(negedge clk);
    ce = 1'b1; we = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    do_read(8'h20, 8'h11, 6);

    idle(6);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/nvram_responder.md
# nvram_responder

Synthesizable NVRAM device model that sits at the far end of the /CE, /WE, /OE strobe bus driven by `SequenceGenerator`. It decodes the active-low strobes and commits writes on the trailing strobe edge. It presents read data after a programmable access latency, and flags protocol violations. It replaces the external NVRAM part for on-chip bring-up and closed-loop simulation against the sequence generator.

## Interface
- `AddrWidth`, 8, address bits; the array holds 2^AddrWidth words.
- `DataWidth`, 8, data word width.
- `AccessCycles`, 3, read access latency in Clk cycles; legal range 1..15.

- `Clk`  in  1  system clock; all inputs are sampled on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `CE`  in  1  chip enable, active low.
- `WE`  in  1  write enable, active low.
- `OE`  in  1  output enable, active low.
- `Addr`  in  AddrWidth  word address.
- `DataIn`  in  DataWidth  write data.
- `DataOut`  out  DataWidth  read data.
- `DataValid`  out  1  DataOut is valid; the top level uses it as the tristate enable.
- `WriteStrobe`  out  1  one-cycle pulse when a word is committed.
- `Error`  out  1  sticky protocol-violation flag.
- `State`  out  2  current FSM state, for debug.

## Operation
- FSM states: IDLE=00, SELECT=01, READ=10, WRITE=11.
- IDLE:
  - CE=0, OE=0, WE=1 → READ.
  - CE=0, WE=0, OE=1 → WRITE.
  - CE=0, both high → SELECT.
  - Otherwise stay in IDLE.
- SELECT: same exits as IDLE; CE=1 → IDLE.
- Any state, CE=0 and WE=0 and OE=0 sampled together:
  - Set Error.
  - Go to SELECT.
  - No write commit and no data drive.
- READ:
  - On entry, latch Addr and load the access counter with AccessCycles.
  - Decrement each cycle.
  - When the counter reaches 0, DataOut ← mem[latched addr] and DataValid=1.
  - Addr sampled different from the latched address → relatch, reload the counter, clear DataValid (models tAA).
  - OE=1 or CE=1 → clear DataValid; go to SELECT if CE=0, else IDLE.
- WRITE:
  - Every cycle, capture Addr and DataIn into holding registers.
  - First edge with WE=1 or CE=1 (trailing strobe): mem[held addr] ← held data, pulse WriteStrobe.
  - Exit to SELECT if CE=0, else IDLE.
  - Addr sampled different from the held address while in WRITE → set Error; the commit still uses the newest held address.
- Memory contents are not affected by Reset. The initial content is undefined; the bench preloads it through write cycles.
- Error clears only on Reset.

## Timing
- Reset values:
  - State=IDLE.
  - DataOut=0.
  - DataValid=0.
  - WriteStrobe=0.
  - Error=0.
  - Counter=0.
  - Holding registers=0.
- Reset mid-cycle: all outputs return to reset values immediately (asynchronous). Any pending write is discarded, not committed.
- Read latency:
  - OE/CE first sampled low at edge N → DataValid=1 after edge N+AccessCycles.
  - DataValid falls after the first edge that samples OE=1 or CE=1.
- Write commit:
  - Occurs at the edge sampling the trailing strobe high. The array and WriteStrobe update on that edge.
  - WriteStrobe is high for exactly one cycle.
  - Data written is from the previous edge's sample.
- A WRITE held for exactly one sampled cycle is legal and commits once.
- Back-to-back cycles:
  - WRITE→READ with CE held low passes through SELECT for at least one cycle.
  - A read of the just-written address returns the new data.
- A strobe held active indefinitely (Extend asserted at the generator) holds READ with DataValid=1, or holds WRITE with no commit, with no timeout.
- Address wrap: Addr is used modulo 2^AddrWidth; there is no out-of-range case.

## Test plan
- Reset: assert Reset with CE=WE=OE=1 → State=00, DataValid=0, WriteStrobe=0, Error=0; deassert and run 20 cycles with strobes high → outputs unchanged.
- Write then read:
  - Write 0xA5 to 0x12 (WE low for 3 cycles) → a single WriteStrobe pulse on the WE-rising edge.
  - Read 0x12 with AccessCycles=3 → DataValid rises exactly 3 edges after OE is sampled low, DataOut=0xA5.
- Trailing CE commit: write 0x3C to 0xFF, then raise CE while WE is still low → WriteStrobe pulses on the CE-rising edge; a subsequent read of 0xFF returns 0x3C.
- Address change during READ:
  - Mid-read, change Addr from 0x12 to 0x13 (0x13 preloaded with 0x5A) → DataValid drops the next cycle.
  - DataValid reasserts 3 cycles later with 0x5A.
- Violation: drive CE=WE=OE=0 for 1 cycle → Error=1, State=SELECT, no WriteStrobe; Error stays 1 through later legal cycles until Reset.
- Reset mid-write: assert Reset while in WRITE with DataIn=0x77 to 0x20 (previously 0x11) → no WriteStrobe; a later read of 0x20 returns 0x11.
